// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 8-bit write-only controller.
// Holds the FSM state encoding, the power-on command ROM and the default timing.
package lcd_pkg;

    localparam int CNT_W    = 20;
    localparam int INIT_LEN = 6;

    localparam int unsigned DEF_T_PWRON = 750000;
    localparam int unsigned DEF_T_SU    = 2;
    localparam int unsigned DEF_T_EN    = 12;
    localparam int unsigned DEF_T_HOLD  = 2;
    localparam int unsigned DEF_T_EXEC  = 2000;
    localparam int unsigned DEF_T_CLR   = 82000;

    // Entry 0 is sent first: function set x3, display on, clear, entry mode.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38
    };

    typedef enum logic [2:0] {
        PWRON_WAIT,
        INIT_LOAD,
        SETUP,
        PULSE,
        HOLD,
        EXEC_WAIT,
        IDLE
    } lcd_state_t;

    // Clear display / return home need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter used to time every FSM state; done is high at zero.
// Counting stops at zero so done stays asserted until the next load.
module lcd_timer
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit bus controller: power-on wait, six-command init, then single
// byte writes from a valid/ready requester with fixed setup/pulse/hold/exec timing.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRON = DEF_T_PWRON,
    parameter int unsigned T_SU    = DEF_T_SU,
    parameter int unsigned T_EN    = DEF_T_EN,
    parameter int unsigned T_HOLD  = DEF_T_HOLD,
    parameter int unsigned T_EXEC  = DEF_T_EXEC,
    parameter int unsigned T_CLR   = DEF_T_CLR
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    // A state lasting N cycles is entered with the timer loaded to N-1.
    // The power-on wait spends its first cycle arming the timer, hence N-2.
    localparam logic [CNT_W-1:0] PWRON_LOAD = (T_PWRON > 1) ? CNT_W'(T_PWRON - 2) : '0;
    localparam logic [CNT_W-1:0] SU_LOAD    = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(T_CLR - 1);

    lcd_state_t       state_reg, state_next;
    logic [7:0]       lcd_data_reg, lcd_data_next;
    logic             lcd_rs_reg, lcd_rs_next;
    logic             lcd_en_reg, lcd_en_next;
    logic [2:0]       init_idx_reg, init_idx_next;
    logic             init_done_reg, init_done_next;
    logic             armed_reg, armed_next;

    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_done;

    lcd_timer u_timer (
        .clk        (clk_clk),
        .rst        (reset_reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg     <= PWRON_WAIT;
            lcd_data_reg  <= 8'h00;
            lcd_rs_reg    <= 1'b0;
            lcd_en_reg    <= 1'b0;
            init_idx_reg  <= '0;
            init_done_reg <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lcd_data_reg  <= lcd_data_next;
            lcd_rs_reg    <= lcd_rs_next;
            lcd_en_reg    <= lcd_en_next;
            init_idx_reg  <= init_idx_next;
            init_done_reg <= init_done_next;
            armed_reg     <= armed_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        lcd_data_next  = lcd_data_reg;
        lcd_rs_next    = lcd_rs_reg;
        lcd_en_next    = lcd_en_reg;
        init_idx_next  = init_idx_reg;
        init_done_next = init_done_reg;
        armed_next     = armed_reg;
        timer_load     = 1'b0;
        timer_value    = '0;

        case (state_reg)
            PWRON_WAIT: begin
                if (!armed_reg) begin
                    armed_next = 1'b1;
                    if (T_PWRON == 1) begin
                        state_next = INIT_LOAD;
                    end else begin
                        timer_load  = 1'b1;
                        timer_value = PWRON_LOAD;
                    end
                end else if (timer_done) begin
                    state_next = INIT_LOAD;
                end
            end
            INIT_LOAD: begin
                lcd_data_next = INIT_ROM[init_idx_reg];
                lcd_rs_next   = 1'b0;
                state_next    = SETUP;
                timer_load    = 1'b1;
                timer_value   = SU_LOAD;
            end
            SETUP: begin
                if (timer_done) begin
                    state_next  = PULSE;
                    lcd_en_next = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = EN_LOAD;
                end
            end
            PULSE: begin
                if (timer_done) begin
                    state_next  = HOLD;
                    lcd_en_next = 1'b0;
                    timer_load  = 1'b1;
                    timer_value = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (timer_done) begin
                    state_next  = EXEC_WAIT;
                    timer_load  = 1'b1;
                    timer_value = is_slow_cmd(lcd_rs_reg, lcd_data_reg) ? CLR_LOAD : EXEC_LOAD;
                end
            end
            EXEC_WAIT: begin
                if (timer_done) begin
                    if (init_done_reg) begin
                        state_next = IDLE;
                    end else if (init_idx_reg == 3'(INIT_LEN - 1)) begin
                        init_done_next = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        init_idx_next = init_idx_reg + 3'd1;
                        state_next    = INIT_LOAD;
                    end
                end
            end
            IDLE: begin
                if (req_valid) begin
                    lcd_data_next = req_data;
                    lcd_rs_next   = req_rs;
                    state_next    = SETUP;
                    timer_load    = 1'b1;
                    timer_value   = SU_LOAD;
                end
            end
            default: begin
                state_next = PWRON_WAIT;
            end
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign init_done = init_done_reg;
    assign lcd_data  = lcd_data_reg;
    assign lcd_rs    = lcd_rs_reg;
    assign lcd_en    = lcd_en_reg;
    // The busy flag is never read, so the bus is write-only.
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: a timeline model of expected bus cycles compared every
// cycle, plus hand-computed pulse positions, gaps and reset values.
module tb_lcd_ctrl;

    localparam int P_PWRON = 10;
    localparam int P_SU    = 2;
    localparam int P_EN    = 3;
    localparam int P_HOLD  = 2;
    localparam int P_EXEC  = 5;
    localparam int P_CLR   = 20;

    logic       clk_clk     = 1'b0;
    logic       reset_reset = 1'b1;
    logic       req_valid   = 1'b0;
    logic       req_rs      = 1'b0;
    logic [7:0] req_data    = 8'h00;
    logic       req_ready, init_done, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    lcd_ctrl #(
        .T_PWRON (P_PWRON),
        .T_SU    (P_SU),
        .T_EN    (P_EN),
        .T_HOLD  (P_HOLD),
        .T_EXEC  (P_EXEC),
        .T_CLR   (P_CLR)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .req_valid   (req_valid),
        .req_rs      (req_rs),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .init_done   (init_done),
        .lcd_data    (lcd_data),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic       ready;
        logic       idone;
        logic       rs;
        logic       en;
        logic [7:0] data;
    } rec_t;

    rec_t       exp_q[$];
    rec_t       cur;
    logic       need_init = 1'b0;
    int         checks    = 0;
    int         errors    = 0;
    logic       cmp_en    = 1'b0;
    int         cyc       = 0;
    int         rise_t[$];
    logic [7:0] rise_d[$];
    int         done_t    = -1;
    logic       prev_en   = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;

    logic [7:0] init_cmds [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int         exp_rise  [6] = '{12, 25, 38, 51, 64, 92};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic ready, input logic idone, input logic rs,
                                input logic en, input logic [7:0] d);
        rec_t r;
        r.ready = ready;
        r.idone = idone;
        r.rs    = rs;
        r.en    = en;
        r.data  = d;
        return r;
    endfunction

    // One bus write as seen on the pins: setup, enable pulse, hold, execution wait.
    task automatic push_write(input logic rs, input logic [7:0] d, input logic idone);
        int wait_n;
        wait_n = (!rs && d >= 8'h01 && d <= 8'h03) ? P_CLR : P_EXEC;
        for (int i = 0; i < P_SU; i++)   exp_q.push_back(mk(1'b0, idone, rs, 1'b0, d));
        for (int i = 0; i < P_EN; i++)   exp_q.push_back(mk(1'b0, idone, rs, 1'b1, d));
        for (int i = 0; i < P_HOLD; i++) exp_q.push_back(mk(1'b0, idone, rs, 1'b0, d));
        for (int i = 0; i < wait_n; i++) exp_q.push_back(mk(1'b0, idone, rs, 1'b0, d));
    endtask

    task automatic build_init();
        logic [7:0] md;
        md = 8'h00;
        for (int i = 0; i < P_PWRON - 1; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, md));
            push_write(1'b0, init_cmds[i], 1'b0);
            md = init_cmds[i];
        end
    endtask

    // Model: advances one expected cycle per rising edge.
    initial begin
        cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        forever begin
            @(posedge clk_clk);
            if (reset_reset) begin
                exp_q.delete();
                cur       = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                need_init = 1'b1;
            end else begin
                if (need_init) begin
                    build_init();
                    need_init = 1'b0;
                end
                if (cur.ready && req_valid) push_write(req_rs, req_data, 1'b1);
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else                  cur = mk(1'b1, 1'b1, cur.rs, 1'b0, cur.data);
            end
        end
    end

    // Compare and monitor on the falling edge.
    initial begin
        forever begin
            @(negedge clk_clk);
            if (reset_reset) begin
                cyc = 0;
            end else begin
                if (cmp_en)
                    check($sformatf("bus@%0d", cyc),
                          {19'b0, req_ready, init_done, lcd_rw, lcd_rs, lcd_en, lcd_data},
                          {19'b0, cur.ready, cur.idone, 1'b0, cur.rs, cur.en, cur.data});
                if (lcd_en && !prev_en) begin
                    rise_t.push_back(cyc);
                    rise_d.push_back(lcd_data);
                end
                if (lcd_en && prev_en) check($sformatf("en_stable@%0d", cyc), lcd_data, prev_data);
                if (init_done && !prev_done) done_t = cyc;
                cyc++;
            end
            prev_en   = lcd_en;
            prev_done = init_done;
            prev_data = lcd_data;
        end
    end

    task automatic wait_init();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_clk);
            if (init_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("init_done_timeout", seen, 1'b1);
        @(negedge clk_clk);
    endtask

    task automatic check_init_literals();
        check("init_rise_count", rise_t.size(), 6);
        for (int i = 0; i < 6 && i < rise_t.size(); i++) begin
            check($sformatf("init_rise_t%0d", i), rise_t[i], exp_rise[i]);
            check($sformatf("init_rise_d%0d", i), rise_d[i], init_cmds[i]);
        end
        check("init_done_cycle", done_t, 102);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {req_ready, init_done, lcd_rw, lcd_rs, lcd_en, lcd_data}, 13'h0);
    endtask

    initial begin
        int n;
        logic seen;

        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check_reset_outputs("reset_values");

        // Requests during power-on and init must be ignored.
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h55;
        cmp_en    = 1'b1;
        #1 reset_reset = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_clk);
            if (lcd_en && lcd_data == 8'h06) break;
        end
        req_valid = 1'b0;
        wait_init();
        check_init_literals();

        // Single character write 0x41.
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h41;
        @(negedge clk_clk);
        req_valid = 1'b0;
        check("accept_capture", {req_ready, lcd_rs, lcd_data}, {1'b0, 1'b1, 8'h41});
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) @(negedge clk_clk);
            check($sformatf("wr41_en@%0d", k), lcd_en, (k >= 3 && k <= 5));
            check($sformatf("wr41_ready@%0d", k), req_ready, (k == 13));
        end

        // Back-to-back: clear (long wait) then set DDRAM address (short wait).
        req_valid = 1'b1;
        req_rs    = 1'b0;
        req_data  = 8'h01;
        @(negedge clk_clk);
        req_data = 8'h80;
        n = 1;
        while (!req_ready && n < 100) begin
            @(negedge clk_clk);
            n++;
        end
        check("clr_ready_gap", n, 28);
        @(negedge clk_clk);
        req_valid = 1'b0;
        n = 1;
        while (!req_ready && n < 100) begin
            @(negedge clk_clk);
            n++;
        end
        check("cmd80_ready_gap", n, 13);
        if (rise_t.size() >= 2) begin
            check("b2b_rise_spacing", rise_t[rise_t.size()-1] - rise_t[rise_t.size()-2], 28);
            check("b2b_first_data", rise_d[rise_d.size()-2], 8'h01);
            check("b2b_second_data", rise_d[rise_d.size()-1], 8'h80);
        end else begin
            check("b2b_rise_count", rise_t.size(), 2);
        end

        // No request: bus stays quiet and holds the last byte.
        repeat (20) @(negedge clk_clk);
        check("idle_hold", {lcd_en, req_ready, lcd_data}, {1'b0, 1'b1, 8'h80});

        // Reset in the middle of an enable pulse.
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        @(negedge clk_clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (lcd_en) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_clk);
        end
        check("pulse_reached", seen, 1'b1);
        check("pulse_data", lcd_data, 8'h5A);
        #1 reset_reset = 1'b1;
        #1 check_reset_outputs("async_reset_mid_pulse");
        rise_t.delete();
        rise_d.delete();
        done_t = -1;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check_reset_outputs("reset_held");
        #1 reset_reset = 1'b0;
        wait_init();
        check_init_literals();
        repeat (5) @(negedge clk_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter T_PWRON, default 750000, power-on wait in clk_clk cycles (15 ms at 50 MHz).
REQ-002 Parameter T_SU, default 2, cycles RS/data are stable before lcd_en rises.
REQ-003 Parameter T_EN, default 12, cycles lcd_en stays high.
REQ-004 Parameter T_HOLD, default 2, cycles RS/data are held after lcd_en falls.
REQ-005 Parameter T_EXEC, default 2000, command/data execution wait (40 us).
REQ-006 Parameter T_CLR, default 82000, clear/home execution wait (1.64 ms).
REQ-007 Port clk_clk  in  1  single system clock; all logic on its rising edge.
REQ-008 Port reset_reset  in  1  asynchronous, active-high reset.
REQ-009 Port req_valid  in  1  requester has a byte to write.
REQ-010 Port req_rs  in  1  0 = command, 1 = character data.
REQ-011 Port req_data  in  8  byte to write.
REQ-012 Port req_ready  out  1  controller accepts a request this cycle.
REQ-013 Port init_done  out  1  power-on init sequence complete; sticky until reset.
REQ-014 Ports lcd_data (out, 8), lcd_rs (out, 1), lcd_rw (out, 1), lcd_en (out, 1) drive the HD44780 8-bit bus; all registered.

Function
REQ-015 States: PWRON_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, EXEC_WAIT, IDLE.
REQ-016 After reset the FSM SHALL stay in PWRON_WAIT for T_PWRON cycles, then enter INIT_LOAD.
REQ-017 The init sequence SHALL write six commands in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (RS=0).
REQ-018 Each write SHALL traverse SETUP (T_SU cycles, en=0), PULSE (T_EN cycles, en=1), HOLD (T_HOLD cycles, en=0), EXEC_WAIT (wait cycles, en=0).
REQ-019 The wait SHALL be T_CLR when RS=0 and data is 0x01, 0x02 or 0x03; otherwise T_EXEC (including RS=0, data 0x00).
REQ-020 After the sixth init write's EXEC_WAIT, init_done SHALL go high and the FSM SHALL enter IDLE.
REQ-021 req_ready SHALL be high exactly while the state is IDLE; it is low during PWRON_WAIT and init, so requests then are ignored and are not queued.
REQ-022 A transfer occurs on an edge where req_valid and req_ready are both 1; req_rs/req_data SHALL be captured into lcd_rs/lcd_data at that edge and the FSM SHALL enter SETUP.
REQ-023 req_ready SHALL be low from the cycle after acceptance until the write's EXEC_WAIT completes; IDLE is then re-entered, and back-to-back requests therefore occur at most every T_SU+T_EN+T_HOLD+wait+1 cycles.
REQ-024 lcd_data/lcd_rs SHALL remain constant from SETUP entry through the end of HOLD; they hold their last value in EXEC_WAIT and IDLE.
REQ-025 lcd_rw SHALL be constant 0 (write-only; busy flag never polled).
REQ-026 req_valid deasserted while req_ready is high SHALL leave the FSM in IDLE with no bus activity.
REQ-027 All timing parameters SHALL be at least 1; the cycle counter SHALL be 20 bits wide, and parameter values of 2^20 or more are illegal.

Reset
REQ-028 While reset_reset=1: lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, req_ready=0, init_done=0, state=PWRON_WAIT, counter and init index cleared.
REQ-029 Reset asserted mid-write (including during PULSE) SHALL drop lcd_en immediately (asynchronously) and restart the full power-on sequence on release.

Structure
REQ-030 Package lcd_pkg SHALL hold the state enum, the 6-entry init command ROM constant, and the default timing constants.
REQ-031 One sub-module lcd_timer: loadable 20-bit down-counter with load and a done output (high when zero). lcd_ctrl loads it with N-1 on entry to each timed state.

Verification (T_PWRON=10, T_SU=2, T_EN=3, T_HOLD=2, T_EXEC=5, T_CLR=20)
REQ-032 Reset release -> lcd_en stays 0 for 10 cycles; then six en pulses of 3 cycles, with data 38,38,38,0C,01,06 respectively; the gap after 01 is 20 cycles; init_done rises afterwards.
REQ-033 After init: req_valid=1, rs=1, data=0x41 for one cycle -> lcd_rs=1 and lcd_data=0x41 next cycle; en high for 3 cycles after 2 setup cycles; req_ready returns exactly 2+3+2+5+1 cycles after acceptance.
REQ-034 req_valid held high with rs=0, data=0x01 then data=0x80 -> first write waits 20 cycles and second waits 5; data is stable throughout each en-high window.
REQ-035 req_valid=1 during PWRON_WAIT/init -> req_ready=0 and the init bus sequence is unchanged.
REQ-036 reset_reset pulsed during PULSE of a data write -> lcd_en=0 in the same cycle, all outputs take their reset values, and the full init sequence replays after release.
